// File: rtl/mdu_pkg.sv
// ============================================================================
//  Module   : mdu_pkg
//  Purpose  : Opcode encodings, default latencies and FSM state type for e_mdu.
//             Optional build macro: MDU_MADD_EN (MADD/MADDU/MSUB/MSUBU).
//  Revision : 1.0
// ============================================================================
`default_nettype none

package mdu_pkg;

    localparam logic [3:0] MD_NOP   = 4'd0;
    localparam logic [3:0] MD_MULT  = 4'd1;
    localparam logic [3:0] MD_MULTU = 4'd2;
    localparam logic [3:0] MD_DIV   = 4'd3;
    localparam logic [3:0] MD_DIVU  = 4'd4;
    localparam logic [3:0] MD_MTHI  = 4'd5;
    localparam logic [3:0] MD_MTLO  = 4'd6;
    localparam logic [3:0] MD_MFHI  = 4'd7;
    localparam logic [3:0] MD_MFLO  = 4'd8;
    localparam logic [3:0] MD_MADD  = 4'd9;
    localparam logic [3:0] MD_MADDU = 4'd10;
    localparam logic [3:0] MD_MSUB  = 4'd11;
    localparam logic [3:0] MD_MSUBU = 4'd12;

    localparam int MULT_CYCLES_DEF = 5;
    localparam int DIV_CYCLES_DEF  = 10;
    localparam int CNT_W           = 16;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    // Operations that occupy the unit for MULT_CYCLES
    function automatic logic is_mul_op(input logic [3:0] op);
`ifdef MDU_MADD_EN
        return (op == MD_MULT) || (op == MD_MULTU) || (op == MD_MADD) ||
               (op == MD_MADDU) || (op == MD_MSUB) || (op == MD_MSUBU);
`else
        return (op == MD_MULT) || (op == MD_MULTU);
`endif
    endfunction

    function automatic logic is_div_op(input logic [3:0] op);
        return (op == MD_DIV) || (op == MD_DIVU);
    endfunction

endpackage

`default_nettype wire

// File: rtl/mdu_calc.sv
// ============================================================================
//  Module   : mdu_calc
//  Purpose  : Combinational 64-bit {HI,LO} result for the latched MDU operation.
//             Optional build macro: MDU_MADD_EN (accumulate into current HI/LO).
//  Revision : 1.0
// ============================================================================
`default_nettype none

module mdu_calc
    import mdu_pkg::*;
(
    input  logic [3:0]  op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic [31:0] hi,
    input  logic [31:0] lo,
    output logic [63:0] result,
    output logic        write_en
);

    logic [63:0] prod_u;
    logic [63:0] prod_s;
    logic [31:0] b_nz;
    logic [31:0] mag_a;
    logic [31:0] mag_b;
    logic [31:0] quot_m;
    logic [31:0] rem_m;
    logic [31:0] quot_s;
    logic [31:0] rem_s;

    assign prod_u = {32'd0, a} * {32'd0, b};
    assign prod_s = {{32{a[31]}}, a} * {{32{b[31]}}, b};

    // Divide on magnitudes; a zero divisor is replaced so the datapath stays defined
    assign b_nz   = (b == 32'd0) ? 32'd1 : b;
    assign mag_a  = a[31] ? (~a + 32'd1) : a;
    assign mag_b  = b_nz[31] ? (~b_nz + 32'd1) : b_nz;
    assign quot_m = mag_a / mag_b;
    assign rem_m  = mag_a % mag_b;
    assign quot_s = (a[31] ^ b_nz[31]) ? (~quot_m + 32'd1) : quot_m;
    assign rem_s  = a[31] ? (~rem_m + 32'd1) : rem_m;

    always_comb begin
        result   = {hi, lo};
        write_en = 1'b0;
        case (op)
            MD_MULT:  begin result = prod_s; write_en = 1'b1; end
            MD_MULTU: begin result = prod_u; write_en = 1'b1; end
            MD_DIV:   begin result = {rem_s, quot_s}; write_en = (b != 32'd0); end
            MD_DIVU:  begin result = {a % b_nz, a / b_nz}; write_en = (b != 32'd0); end
`ifdef MDU_MADD_EN
            MD_MADD:  begin result = {hi, lo} + prod_s; write_en = 1'b1; end
            MD_MADDU: begin result = {hi, lo} + prod_u; write_en = 1'b1; end
            MD_MSUB:  begin result = {hi, lo} - prod_s; write_en = 1'b1; end
            MD_MSUBU: begin result = {hi, lo} - prod_u; write_en = 1'b1; end
`endif
            default:  ;
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/e_mdu.sv
// ============================================================================
//  Module   : e_mdu
//  Purpose  : E-stage multiply/divide unit with fixed latency and HI/LO state.
//             Optional build macro: MDU_MADD_EN (MADD/MADDU/MSUB/MSUBU).
//  Revision : 1.0
// ============================================================================
`default_nettype none

module e_mdu
    import mdu_pkg::*;
#(
    parameter int MULT_CYCLES = MULT_CYCLES_DEF,
    parameter int DIV_CYCLES  = DIV_CYCLES_DEF
)(
    input  logic        Clk,
    input  logic        Rst,
    input  logic        Start,
    input  logic [3:0]  MDOp,
    input  logic [31:0] A,
    input  logic [31:0] B,
    input  logic        Flush,
    output logic        Busy,
    output logic [31:0] HILO_out,
    output logic [31:0] HI,
    output logic [31:0] LO
);

    localparam logic [CNT_W-1:0] MULT_LOAD = CNT_W'(MULT_CYCLES);
    localparam logic [CNT_W-1:0] DIV_LOAD  = CNT_W'(DIV_CYCLES);

    state_t           state;
    logic [CNT_W-1:0] count;
    logic [3:0]       op_q;
    logic [31:0]      a_q;
    logic [31:0]      b_q;
    logic [63:0]      calc_result;
    logic             calc_we;

    mdu_calc u_calc (
        .op       (op_q),
        .a        (a_q),
        .b        (b_q),
        .hi       (HI),
        .lo       (LO),
        .result   (calc_result),
        .write_en (calc_we)
    );

    always_ff @(posedge Clk) begin
        if (Rst) begin
            state <= IDLE;
            count <= '0;
            op_q  <= MD_NOP;
            a_q   <= '0;
            b_q   <= '0;
            Busy  <= 1'b0;
            HI    <= '0;
            LO    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (!Flush) begin
                        if (Start && (is_mul_op(MDOp) || is_div_op(MDOp))) begin
                            op_q  <= MDOp;
                            a_q   <= A;
                            b_q   <= B;
                            count <= is_div_op(MDOp) ? DIV_LOAD : MULT_LOAD;
                            state <= RUN;
                            Busy  <= 1'b1;
                        end else if (MDOp == MD_MTHI) begin
                            HI <= A;
                        end else if (MDOp == MD_MTLO) begin
                            LO <= A;
                        end
                    end
                end
                RUN: begin
                    count <= count - 1'b1;
                    // Final busy cycle: commit (unless divide-by-zero) and release
                    if (count == CNT_W'(1)) begin
                        if (calc_we) begin
                            {HI, LO} <= calc_result;
                        end
                        state <= IDLE;
                        Busy  <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_comb begin
        HILO_out = 32'd0;
        case (MDOp)
            MD_MFHI: HILO_out = HI;
            MD_MFLO: HILO_out = LO;
            default: HILO_out = 32'd0;
        endcase
    end

endmodule

`default_nettype wire

// File: tb/tb_e_mdu.sv
// ============================================================================
//  Module   : tb_e_mdu
//  Purpose  : Scoreboard bench for e_mdu with a 64-bit arithmetic reference.
//  Revision : 1.0
// ============================================================================
`default_nettype none

module tb_e_mdu;
    import mdu_pkg::*;

    logic        Clk = 1'b0;
    logic        Rst;
    logic        Start;
    logic [3:0]  MDOp;
    logic [31:0] A;
    logic [31:0] B;
    logic        Flush;
    logic        Busy;
    logic [31:0] HILO_out;
    logic [31:0] HI;
    logic [31:0] LO;

    int          checks = 0;
    int          errors = 0;
    logic [63:0] exp_q[$];
    logic [63:0] mon_exp;
    logic [31:0] m_hi;
    logic [31:0] m_lo;
    logic        rst_seen  = 1'b0;
    logic        prev_busy = 1'b0;
    logic [3:0]  ops[8];

    e_mdu #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
        .Clk      (Clk),
        .Rst      (Rst),
        .Start    (Start),
        .MDOp     (MDOp),
        .A        (A),
        .B        (B),
        .Flush    (Flush),
        .Busy     (Busy),
        .HILO_out (HILO_out),
        .HI       (HI),
        .LO       (LO)
    );

    always #5 Clk = ~Clk;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", name, got, exp);
        end
    endtask

    // Reference: plain 64-bit integer arithmetic on the architectural rules
    function automatic logic [63:0] ref_exec(input logic [3:0] op, input logic [31:0] a,
                                             input logic [31:0] b, input logic [63:0] base);
        longint          sa, sb, q, r;
        longint unsigned ua, ub;
        logic [63:0]     res;
        res = base;
        sa  = longint'($signed(a));
        sb  = longint'($signed(b));
        ua  = a;
        ub  = b;
        case (op)
            MD_MULT:  res = sa * sb;
            MD_MULTU: res = ua * ub;
            MD_DIV:   if (b != 0) begin q = sa / sb; r = sa % sb; res = {r[31:0], q[31:0]}; end
            MD_DIVU:  if (b != 0) res = {32'(ua % ub), 32'(ua / ub)};
            MD_MADD:  res = base + sa * sb;
            MD_MADDU: res = base + ua * ub;
            MD_MSUB:  res = base - sa * sb;
            MD_MSUBU: res = base - ua * ub;
            default:  res = base;
        endcase
        return res;
    endfunction

    always @(posedge Clk) rst_seen <= Rst;

    always @(posedge Clk) begin
        if (Rst === 1'b0) begin
            assert (!(Start && !Flush && Busy)) else $error("FAIL start_while_busy");
        end
    end

    // Monitor: every falling Busy not caused by reset is a commit to score
    always @(negedge Clk) begin
        if (prev_busy === 1'b1 && Busy === 1'b0 && !rst_seen) begin
            if (exp_q.size() == 0) begin
                check("unexpected_commit", 64'd1, 64'd0);
            end else begin
                mon_exp = exp_q.pop_front();
                check("commit_hilo", {HI, LO}, mon_exp);
            end
        end
        prev_busy <= Busy;
    end

    task automatic run_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                          input int n);
        logic [63:0] e;
        int          cyc;
        e = ref_exec(op, a, b, {m_hi, m_lo});
        exp_q.push_back(e);
        {m_hi, m_lo} = e;
        @(negedge Clk);
        check("busy_in_start_cycle", {63'd0, Busy}, 64'd0);
        Start = 1'b1; MDOp = op; A = a; B = b;
        @(negedge Clk);
        Start = 1'b0; MDOp = MD_NOP; A = $urandom; B = $urandom;
        cyc = 0;
        while (Busy === 1'b1 && cyc < 50) begin
            cyc++;
            @(negedge Clk);
        end
        check("busy_length", 64'(cyc), 64'(n));
    endtask

    task automatic write_mt(input logic [3:0] op, input logic [31:0] v);
        @(negedge Clk);
        MDOp = op; A = v;
        @(negedge Clk);
        MDOp = MD_NOP;
        if (op == MD_MTHI) m_hi = v; else m_lo = v;
        check("mt_write", {HI, LO}, {m_hi, m_lo});
    endtask

    initial begin
        Rst = 1'b1; Start = 1'b0; Flush = 1'b0; MDOp = MD_NOP; A = '0; B = '0;
        ops[0] = MD_MULT;  ops[1] = MD_MULTU; ops[2] = MD_DIV;  ops[3] = MD_DIVU;
        ops[4] = MD_MADD;  ops[5] = MD_MADDU; ops[6] = MD_MSUB; ops[7] = MD_MSUBU;
        repeat (2) @(negedge Clk);
        Rst = 1'b0; m_hi = '0; m_lo = '0;
        check("reset_busy", {63'd0, Busy}, 64'd0);
        check("reset_hilo", {HI, LO}, 64'd0);
        check("reset_hilo_out", {32'd0, HILO_out}, 64'd0);

        run_op(MD_MULT, 32'hFFFF_FFFE, 32'd3, 5);
        check("mult_neg", {HI, LO}, 64'hFFFF_FFFF_FFFF_FFFA);
        run_op(MD_DIVU, 32'd100, 32'd7, 10);
        check("divu_basic", {HI, LO}, {32'd2, 32'd14});
        run_op(MD_DIV, 32'hFFFF_FFF9, 32'd2, 10);
        check("div_neg", {HI, LO}, 64'hFFFF_FFFF_FFFF_FFFD);

        write_mt(MD_MTHI, 32'h1234);
        write_mt(MD_MTLO, 32'h5678);
        run_op(MD_DIV, 32'd5, 32'd0, 10);
        check("div_by_zero", {HI, LO}, {32'h1234, 32'h5678});
        run_op(MD_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 10);
        check("div_overflow", {HI, LO}, {32'h0, 32'h8000_0000});

        // Reset during the third RUN cycle aborts without a commit
        @(negedge Clk);
        Start = 1'b1; MDOp = MD_MULTU; A = 32'hFFFF_FFFF; B = 32'hFFFF_FFFF;
        @(negedge Clk);
        Start = 1'b0; MDOp = MD_NOP;
        repeat (2) @(negedge Clk);
        Rst = 1'b1;
        @(negedge Clk);
        Rst = 1'b0; m_hi = '0; m_lo = '0;
        check("abort_busy", {63'd0, Busy}, 64'd0);
        check("abort_hilo", {HI, LO}, 64'd0);
        repeat (15) @(negedge Clk);
        check("abort_no_commit", {HI, LO}, 64'd0);

        // Flushed Start and flushed MTHI are both ignored
        write_mt(MD_MTLO, 32'hCAFE);
        @(negedge Clk);
        Start = 1'b1; Flush = 1'b1; MDOp = MD_MULT; A = 32'd3; B = 32'd4;
        @(negedge Clk);
        check("flush_busy", {63'd0, Busy}, 64'd0);
        Start = 1'b0; MDOp = MD_MTHI; A = 32'hDEAD;
        @(negedge Clk);
        Flush = 1'b0; MDOp = MD_NOP;
        repeat (3) @(negedge Clk);
        check("flush_busy_later", {63'd0, Busy}, 64'd0);
        check("flush_hilo", {HI, LO}, {m_hi, m_lo});
        MDOp = MD_MFLO; #1;
        check("mflo", {32'd0, HILO_out}, {32'd0, m_lo});
        MDOp = MD_MFHI; #1;
        check("mfhi", {32'd0, HILO_out}, {32'd0, m_hi});
        MDOp = MD_NOP; #1;
        check("nop_hilo_out", {32'd0, HILO_out}, 64'd0);

`ifdef MDU_MADD_EN
        write_mt(MD_MTHI, 32'd0);
        write_mt(MD_MTLO, 32'hFFFF_FFFF);
        run_op(MD_MADDU, 32'd1, 32'd1, 5);
        check("maddu_carry", {HI, LO}, {32'd1, 32'd0});
`else
        @(negedge Clk);
        Start = 1'b1; MDOp = MD_MADDU; A = 32'd1; B = 32'd1;
        @(negedge Clk);
        Start = 1'b0; MDOp = MD_NOP;
        for (int i = 0; i < 3; i++) begin
            check("madd_disabled_busy", {63'd0, Busy}, 64'd0);
            @(negedge Clk);
        end
        check("madd_disabled_hilo", {HI, LO}, {m_hi, m_lo});
`endif

        for (int i = 0; i < 40; i++) begin
            int          k;
            logic [31:0] ra;
            logic [31:0] rb;
            logic [3:0]  op;
`ifdef MDU_MADD_EN
            k = $urandom_range(0, 9);
`else
            k = $urandom_range(0, 5);
`endif
            ra = $urandom;
            rb = ($urandom_range(0, 7) == 0) ? 32'd0 : $urandom;
            if (k == 4 || k == 5) begin
                write_mt((k == 4) ? MD_MTHI : MD_MTLO, ra);
            end else begin
                op = (k > 5) ? ops[k - 2] : ops[k];
                if (op == MD_DIV && $urandom_range(0, 7) == 0) begin
                    ra = 32'h8000_0000; rb = 32'hFFFF_FFFF;
                end
                run_op(op, ra, rb, is_div_op(op) ? 10 : 5);
            end
        end

        repeat (3) @(negedge Clk);
        check("queue_empty", 64'(exp_q.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
